// File: rtl/lr_d_h_feeder.sv
// Two-column H cache that replays forward-pass pre-activations in step with the returning gradient.
// Optional sticky empty-pop flag on h_underflow_out when LR_D_H_UNDERFLOW_FLAG_EN is defined.
module lr_d_h_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      h_wr_valid_in,
  input  logic signed [15:0]        h_wr_1_in,
  input  logic signed [15:0]        h_wr_2_in,
  output logic                      h_full_out,
  input  logic                      lr_d_valid_1_in,
  input  logic                      lr_d_valid_2_in,
  input  logic signed [15:0]        lr_d_data_1_in,
  input  logic signed [15:0]        lr_d_data_2_in,
  output logic                      lr_d_valid_1_out,
  output logic                      lr_d_valid_2_out,
  output logic signed [15:0]        lr_d_data_1_out,
  output logic signed [15:0]        lr_d_data_2_out,
  output logic signed [15:0]        lr_d_H_1_out,
  output logic signed [15:0]        lr_d_H_2_out,
  output logic [$clog2(DEPTH):0]    h_count_1_out,
  output logic [$clog2(DEPTH):0]    h_count_2_out
`ifdef LR_D_H_UNDERFLOW_FLAG_EN
  ,
  output logic                      h_underflow_out
`endif
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  logic signed [DATA_W-1:0] mem_1 [DEPTH];
  logic signed [DATA_W-1:0] mem_2 [DEPTH];

  logic [AW-1:0] wr_ptr_1, wr_ptr_2;
  logic [AW-1:0] rd_ptr_1, rd_ptr_2;
  logic [CW-1:0] cnt_1, cnt_2;

  logic                     wr_en;
  logic                     pop_1, pop_2;
  logic signed [DATA_W-1:0] rd_h_1_p0, rd_h_2_p0;

  logic                     vld_1_p1, vld_2_p1;
  logic signed [DATA_W-1:0] data_1_p1, data_2_p1;
  logic signed [DATA_W-1:0] h_1_p1, h_2_p1;

  // Stage p0: admission, pop qualification and combinational read of the oldest entry
  assign h_full_out = (cnt_1 == CW'(DEPTH)) || (cnt_2 == CW'(DEPTH));
  assign wr_en      = h_wr_valid_in && !h_full_out;
  assign pop_1      = lr_d_valid_1_in && (cnt_1 != '0);
  assign pop_2      = lr_d_valid_2_in && (cnt_2 != '0);

  // An empty pop reads zero; a same-cycle write is never bypassed into the read.
  assign rd_h_1_p0  = pop_1 ? mem_1[rd_ptr_1] : '0;
  assign rd_h_2_p0  = pop_2 ? mem_2[rd_ptr_2] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_1[wr_ptr_1] <= h_wr_1_in;
      mem_2[wr_ptr_2] <= h_wr_2_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_1 <= '0;
      wr_ptr_2 <= '0;
      rd_ptr_1 <= '0;
      rd_ptr_2 <= '0;
      cnt_1    <= '0;
      cnt_2    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_1 <= wr_ptr_1 + 1'b1;
        wr_ptr_2 <= wr_ptr_2 + 1'b1;
      end
      if (pop_1) rd_ptr_1 <= rd_ptr_1 + 1'b1;
      if (pop_2) rd_ptr_2 <= rd_ptr_2 + 1'b1;
      cnt_1 <= cnt_1 + CW'(wr_en) - CW'(pop_1);
      cnt_2 <= cnt_2 + CW'(wr_en) - CW'(pop_2);
    end
  end

  // Stage p1: registered outputs; data and H hold while their column is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_1_p1  <= 1'b0;
      vld_2_p1  <= 1'b0;
      data_1_p1 <= '0;
      data_2_p1 <= '0;
      h_1_p1    <= '0;
      h_2_p1    <= '0;
    end else begin
      vld_1_p1 <= lr_d_valid_1_in;
      vld_2_p1 <= lr_d_valid_2_in;
      if (lr_d_valid_1_in) begin
        data_1_p1 <= lr_d_data_1_in;
        h_1_p1    <= rd_h_1_p0;
      end
      if (lr_d_valid_2_in) begin
        data_2_p1 <= lr_d_data_2_in;
        h_2_p1    <= rd_h_2_p0;
      end
    end
  end

`ifdef LR_D_H_UNDERFLOW_FLAG_EN
  logic underflow_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_p1 <= 1'b0;
    end else if ((lr_d_valid_1_in && (cnt_1 == '0)) ||
                 (lr_d_valid_2_in && (cnt_2 == '0))) begin
      underflow_p1 <= 1'b1;
    end
  end

  assign h_underflow_out = underflow_p1;
`endif

  assign lr_d_valid_1_out = vld_1_p1;
  assign lr_d_valid_2_out = vld_2_p1;
  assign lr_d_data_1_out  = data_1_p1;
  assign lr_d_data_2_out  = data_2_p1;
  assign lr_d_H_1_out     = h_1_p1;
  assign lr_d_H_2_out     = h_2_p1;
  assign h_count_1_out    = cnt_1;
  assign h_count_2_out    = cnt_2;

endmodule

// File: tb/tb_lr_d_h_feeder.sv
// Directed bench for lr_d_h_feeder: ordering, full/empty boundaries, wrap and reset.
module tb_lr_d_h_feeder;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst;
  logic                 h_wr_valid_in;
  logic signed [15:0]   h_wr_1_in, h_wr_2_in;
  logic                 h_full_out;
  logic                 lr_d_valid_1_in, lr_d_valid_2_in;
  logic signed [15:0]   lr_d_data_1_in, lr_d_data_2_in;
  logic                 lr_d_valid_1_out, lr_d_valid_2_out;
  logic signed [15:0]   lr_d_data_1_out, lr_d_data_2_out;
  logic signed [15:0]   lr_d_H_1_out, lr_d_H_2_out;
  logic [CW-1:0]        h_count_1_out, h_count_2_out;
`ifdef LR_D_H_UNDERFLOW_FLAG_EN
  logic                 h_underflow_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lr_d_h_feeder #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .h_wr_valid_in    (h_wr_valid_in),
    .h_wr_1_in        (h_wr_1_in),
    .h_wr_2_in        (h_wr_2_in),
    .h_full_out       (h_full_out),
    .lr_d_valid_1_in  (lr_d_valid_1_in),
    .lr_d_valid_2_in  (lr_d_valid_2_in),
    .lr_d_data_1_in   (lr_d_data_1_in),
    .lr_d_data_2_in   (lr_d_data_2_in),
    .lr_d_valid_1_out (lr_d_valid_1_out),
    .lr_d_valid_2_out (lr_d_valid_2_out),
    .lr_d_data_1_out  (lr_d_data_1_out),
    .lr_d_data_2_out  (lr_d_data_2_out),
    .lr_d_H_1_out     (lr_d_H_1_out),
    .lr_d_H_2_out     (lr_d_H_2_out),
    .h_count_1_out    (h_count_1_out),
    .h_count_2_out    (h_count_2_out)
`ifdef LR_D_H_UNDERFLOW_FLAG_EN
    ,
    .h_underflow_out  (h_underflow_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_wr_valid_in   = 1'b0;
    lr_d_valid_1_in = 1'b0;
    lr_d_valid_2_in = 1'b0;
  endtask

  task automatic push(input logic signed [15:0] a, input logic signed [15:0] b);
    h_wr_valid_in = 1'b1;
    h_wr_1_in     = a;
    h_wr_2_in     = b;
  endtask

  task automatic pop1(input logic signed [15:0] d);
    lr_d_valid_1_in = 1'b1;
    lr_d_data_1_in  = d;
  endtask

  task automatic pop2(input logic signed [15:0] d);
    lr_d_valid_2_in = 1'b1;
    lr_d_data_2_in  = d;
  endtask

  initial begin
    // Reset with non-idle inputs.
    rst = 1'b1;
    h_wr_1_in = 16'sd9; h_wr_2_in = 16'sd9;
    lr_d_data_1_in = 16'sd9; lr_d_data_2_in = 16'sd9;
    idle();
    tick(); tick();
    rst = 1'b0;
    check("rst_vld1",  32'(lr_d_valid_1_out), 32'd0);
    check("rst_vld2",  32'(lr_d_valid_2_out), 32'd0);
    check("rst_data1", 32'(lr_d_data_1_out), 32'd0);
    check("rst_h2",    32'(lr_d_H_2_out),    32'd0);
    check("rst_cnt1",  32'(h_count_1_out),   32'd0);
    check("rst_full",  32'(h_full_out),      32'd0);
`ifdef LR_D_H_UNDERFLOW_FLAG_EN
    check("rst_uflow", 32'(h_underflow_out), 32'd0);
`endif

    // Ordered replay with column 2 lagging column 1 by one cycle.
    push(16'sd1, 16'sd2); tick();
    push(16'sd3, 16'sd4); tick();
    push(16'sd5, 16'sd6); tick();
    idle();
    check("seq_cnt1", 32'(h_count_1_out), 32'd3);
    check("seq_cnt2", 32'(h_count_2_out), 32'd3);
    pop1(16'sh11); tick();
    check("seqA_vld1", 32'(lr_d_valid_1_out), 32'd1);
    check("seqA_h1",   32'(lr_d_H_1_out),     32'd1);
    check("seqA_d1",   32'(lr_d_data_1_out),  32'h11);
    check("seqA_vld2", 32'(lr_d_valid_2_out), 32'd0);
    pop1(16'sh22); pop2(16'sh33); tick();
    check("seqB_h1",   32'(lr_d_H_1_out),     32'd3);
    check("seqB_h2",   32'(lr_d_H_2_out),     32'd2);
    check("seqB_d2",   32'(lr_d_data_2_out),  32'h33);
    pop1(16'sh44); pop2(16'sh55); tick();
    check("seqC_h1",   32'(lr_d_H_1_out),     32'd5);
    check("seqC_h2",   32'(lr_d_H_2_out),     32'd4);
    lr_d_valid_1_in = 1'b0; pop2(16'sh66); tick();
    check("seqD_vld1", 32'(lr_d_valid_1_out), 32'd0);
    check("seqD_h1",   32'(lr_d_H_1_out),     32'd5);
    check("seqD_d1",   32'(lr_d_data_1_out),  32'h44);
    check("seqD_h2",   32'(lr_d_H_2_out),     32'd6);
    check("seqD_d2",   32'(lr_d_data_2_out),  32'h66);
    idle(); tick();
    check("seqE_vld2", 32'(lr_d_valid_2_out), 32'd0);
    check("seqE_h2",   32'(lr_d_H_2_out),     32'd6);
    check("seqE_cnt1", 32'(h_count_1_out),    32'd0);
    check("seqE_cnt2", 32'(h_count_2_out),    32'd0);

    // Pop of an empty column.
    pop1(16'sh0100); tick(); idle();
    check("emp_vld1", 32'(lr_d_valid_1_out), 32'd1);
    check("emp_d1",   32'(lr_d_data_1_out),  32'h0100);
    check("emp_h1",   32'(lr_d_H_1_out),     32'd0);
    check("emp_cnt1", 32'(h_count_1_out),    32'd0);
`ifdef LR_D_H_UNDERFLOW_FLAG_EN
    check("emp_uflow", 32'(h_underflow_out), 32'd1);
`endif

    // Fill to DEPTH, then one dropped write, then drain in order.
    for (int i = 1; i <= 17; i++) begin
      push(16'(i), 16'(100 + i)); tick();
      if (i == 15) check("fill15_full", 32'(h_full_out), 32'd0);
      if (i == 16) check("fill16_full", 32'(h_full_out), 32'd1);
    end
    idle();
    check("fill17_cnt1", 32'(h_count_1_out), 32'd16);
    check("fill17_cnt2", 32'(h_count_2_out), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      pop1(16'(i)); pop2(16'(i)); tick();
      check("drain_h1", 32'(lr_d_H_1_out), 32'(i));
      check("drain_h2", 32'(lr_d_H_2_out), 32'(100 + i));
    end
    idle();
    check("drain_cnt1", 32'(h_count_1_out), 32'd0);
    check("drain_full", 32'(h_full_out),    32'd0);

    // Simultaneous write and pop at count 4.
    for (int i = 1; i <= 4; i++) begin
      push(16'(200 + i), 16'(300 + i)); tick();
    end
    push(16'sd205, 16'sd305); pop1(16'sd1); tick(); idle();
    check("wp_cnt1", 32'(h_count_1_out), 32'd4);
    check("wp_h1",   32'(lr_d_H_1_out),  32'd201);
    check("wp_cnt2", 32'(h_count_2_out), 32'd5);

    // Twenty write/pop cycles across the pointer wrap.
    for (int j = 0; j < 20; j++) begin
      push(16'(206 + j), 16'(306 + j)); pop1(16'(j)); pop2(16'(j)); tick();
      check("wrap_h1", 32'(lr_d_H_1_out), 32'(202 + j));
      check("wrap_h2", 32'(lr_d_H_2_out), 32'(301 + j));
    end
    idle();
    check("wrap_cnt1", 32'(h_count_1_out), 32'd4);
    check("wrap_cnt2", 32'(h_count_2_out), 32'd5);

    // Mid-stream reset with stored entries and busy inputs.
    push(16'sd7, 16'sd8); tick();
    check("pre_rst_cnt1", 32'(h_count_1_out), 32'd5);
    push(16'sd9, 16'sd9); pop1(16'sh0AA); pop2(16'sh0BB);
    rst = 1'b1; tick();
    rst = 1'b0; idle();
    check("mrst_vld1",  32'(lr_d_valid_1_out), 32'd0);
    check("mrst_d2",    32'(lr_d_data_2_out),  32'd0);
    check("mrst_h1",    32'(lr_d_H_1_out),     32'd0);
    check("mrst_cnt1",  32'(h_count_1_out),    32'd0);
    check("mrst_cnt2",  32'(h_count_2_out),    32'd0);
    check("mrst_full",  32'(h_full_out),       32'd0);
    pop1(16'sd7); pop2(16'sd7); tick(); idle();
    check("mrst_pop_h1", 32'(lr_d_H_1_out),    32'd0);
    check("mrst_pop_h2", 32'(lr_d_H_2_out),    32'd0);
    check("mrst_pop_d1", 32'(lr_d_data_1_out), 32'd7);

    // Write into an empty column on the same cycle as a pop: no bypass.
    push(16'sh55, 16'sh66); pop1(16'sd1); tick(); idle();
    check("nb_h1",   32'(lr_d_H_1_out),  32'd0);
    check("nb_cnt1", 32'(h_count_1_out), 32'd1);
    check("nb_cnt2", 32'(h_count_2_out), 32'd1);
    pop1(16'sd2); tick(); idle();
    check("nb_next_h1", 32'(lr_d_H_1_out),  32'h55);
    check("nb_next_c1", 32'(h_count_1_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
